systolic_controller: RTL and testbench
======================================

// Module: systolic_controller
// PURPOSE
//  Sequences one C = A x B pass on the NxN output-stationary systolic array.
//  - Clears the accumulators, then fetches K columns of A and K rows of B from operand buffers.
//  - Skews the lanes (lane i delayed i cycles) and drives the array edge inputs and pe_enable.
//  - Waits for the wavefront to drain, then flags results valid.
//  Sits between the host/DMA start handshake and systolic_array.
// PARAMETERS
//  N           4   array dimension (lanes per edge)
//  DATA_WIDTH  16  operand width, signed
//  MAX_K       64  maximum inner dimension; buffer depth
//  ADDR_WIDTH  $clog2(MAX_K)  operand buffer address width
// PORTS
//  clk              in   1             clock, rising edge
//  reset            in   1             async, active-low; all state/outputs cleared while low
//  start            in   1             pulse; begin a pass when idle
//  abort            in   1             sync; cancel pass in progress
//  k_len            in   ADDR_WIDTH+1  inner dimension K, sampled on accepted start
//  busy             out  1             high from accepted start until done/abort
//  done             out  1             1-cycle pulse at pass completion
//  result_valid     out  1             array results stable and complete
//  a_rd_en          out  1             A buffer read strobe
//  a_rd_addr        out  ADDR_WIDTH    k index; word = column k of A, lane i = A[i][k]
//  a_rd_data        in   N*DATA_WIDTH  valid 1 cycle after a_rd_en
//  b_rd_en          out  1             B buffer read strobe
//  b_rd_addr        out  ADDR_WIDTH    k index; word = row k of B, lane j = B[k][j]
//  b_rd_data        in   N*DATA_WIDTH  valid 1 cycle after b_rd_en
//  array_clear      out  1             active-high accumulator clear to array
//  pe_enable        out  1             array MAC/shift enable
//  array_in_a_flat  out  N*DATA_WIDTH  skewed A lanes, lane i at [(i+1)*DW-1 -: DW]
//  array_in_b_flat  out  N*DATA_WIDTH  skewed B lanes, same packing
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; skew registers 0.
//  States and transitions:
//  - IDLE -> CLEAR on start.
//  - CLEAR (1 cycle, array_clear=1, pe_enable=0) -> FEED, or -> DONE if K==0.
//  - FEED (K cycles): rd_en=1, rd_addr = 0..K-1 -> DRAIN.
//  - DRAIN (2N cycles, DRAIN_CYCLES) -> DONE.
//  - DONE (1 cycle: done=1, result_valid rises) -> IDLE.
//  pe_enable: 1 in FEED and DRAIN only.
//  Read-valid: rd_en delayed 1 cycle. Lane data enters the skew path only when read-valid; otherwise 0.
//  - Padding slots therefore add 0 to accumulators.
//  Skew: lane i of A and B passes through i register stages (lane 0 combinational from read data).
//  - Stages shift on every clk while busy and hold while idle.
//  DRAIN length derivation: last operand is issued at FEED cycle K-1.
//  - +1 buffer latency, +(N-1) skew, +(N-1) PE hops, +1 accumulate edge = 2N cycles.
//  result_valid: set in DONE; stays 1 in IDLE until the next accepted start (cleared in CLEAR).
//  k_len > MAX_K saturates to MAX_K. K is latched and ignored while busy.
//  start while busy: ignored, no queueing. start and abort in the same cycle while IDLE: start wins.
//  abort while busy: next state IDLE, no done, result_valid=0, skew registers zeroed.
//  reset low mid-pass: immediate return to IDLE, outputs 0; a pass needs a fresh start.
//  Counters: k counter ADDR_WIDTH+1 bits; drain counter $clog2(2N+1) bits; no wrap in a legal pass.
//  Total latency, start to done: K + 2N + 2 cycles (K>0); 2 cycles for K==0.
// STRUCTURE
//  systolic_pkg: state encoding localparams (IDLE, CLEAR, FEED, DRAIN, DONE), DRAIN_CYCLES = 2*N.
//  Sub-module skew_buffer #(N, DATA_WIDTH): one per operand edge.
//  - Triangular delay line with lane i delayed i cycles; zero-fill and synchronous flush input (abort).
//  Controller proper: FSM, k and drain counters, read-valid register.
// TESTING
//  1) N=4, K=4, A=I, B=1..16 row-major, 1-cycle model buffers -> done at cycle 14; C==B; result_valid held.
//  2) K=1, A col=[1,2,3,4], B row=[5,6,7,8] -> C[i][j]=a_i*b_j; done after 1+2N+2 = 11 cycles.
//  3) K=0 -> array_clear then done two cycles after start; C all 0; no rd_en pulse.
//  4) start pulsed every cycle during pass, k_len changed -> single done; K unchanged; results match first K.
//  5) abort at FEED cycle 2 -> busy falls next cycle, no done; new start gives correct full result.
//  6) reset low mid-DRAIN -> all outputs 0 asynchronously; after release, full pass with signed -32768 operands matches model.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Drain lasts this many cycles per lane of array dimension.
   localparam int DRAIN_PER_LANE = 2;

   function automatic logic [31:0] sat_limit(input logic [31:0] value, input logic [31:0] limit);
      logic [31:0] res;
      if (value > limit) begin
         res = limit;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/skew_buffer.sv
// Triangular delay line: lane i is delayed i cycles, with zero-fill and a synchronous flush.
module skew_buffer #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    shift_en,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [N*DATA_WIDTH-1:0] in_flat,
   output logic [N*DATA_WIDTH-1:0] out_flat
);

   logic [N*DATA_WIDTH-1:0] lane_in_s;

   // Slots without valid read data inject zeros so they add nothing downstream
   always_comb begin
      if (in_valid) begin
         lane_in_s = in_flat;
      end else begin
         lane_in_s = '0;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_pass
         assign out_flat[DATA_WIDTH-1:0] = lane_in_s[DATA_WIDTH-1:0];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] pipe_r [i];

         // Lane delay stages: shift while the pass runs, hold while idle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < i; s++) pipe_r[s] <= '0;
            end else if (flush) begin
               for (int s = 0; s < i; s++) pipe_r[s] <= '0;
            end else if (shift_en) begin
               pipe_r[0] <= lane_in_s[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
               for (int s = 1; s < i; s++) pipe_r[s] <= pipe_r[s-1];
            end
         end

         assign out_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = pipe_r[i-1];
      end
   end

endmodule

// File: rtl/systolic_controller.sv
// Sequences one C = A x B pass: clear, operand fetch with lane skew, drain, results valid.
module systolic_controller
   import systolic_pkg::*;
#(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_K      = 64,
   parameter int ADDR_WIDTH = $clog2(MAX_K)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_WIDTH:0]     k_len,
   output logic                    busy,
   output logic                    done,
   output logic                    result_valid,
   output logic                    a_rd_en,
   output logic [ADDR_WIDTH-1:0]   a_rd_addr,
   input  logic [N*DATA_WIDTH-1:0] a_rd_data,
   output logic                    b_rd_en,
   output logic [ADDR_WIDTH-1:0]   b_rd_addr,
   input  logic [N*DATA_WIDTH-1:0] b_rd_data,
   output logic                    array_clear,
   output logic                    pe_enable,
   output logic [N*DATA_WIDTH-1:0] array_in_a_flat,
   output logic [N*DATA_WIDTH-1:0] array_in_b_flat
);

   localparam int KW           = ADDR_WIDTH + 1;
   localparam int DRAIN_CYCLES = DRAIN_PER_LANE * N;
   localparam int DRAIN_CW     = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_CYCLES - 1);
   localparam logic [DRAIN_CW-1:0] DRAIN_ONE  = DRAIN_CW'(1);
   localparam logic [KW-1:0]       K_ONE      = KW'(1);

   state_e                state_r;
   logic [KW-1:0]         k_len_r;
   logic [KW-1:0]         k_cnt_r;
   logic [DRAIN_CW-1:0]   drain_cnt_r;
   logic                  rd_en_r;
   logic [ADDR_WIDTH-1:0] rd_addr_r;
   logic                  rd_valid_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  result_valid_r;
   logic                  array_clear_r;
   logic                  pe_enable_r;

   logic [KW-1:0]         k_sat_s;
   logic [KW-1:0]         k_next_s;
   logic                  k_last_s;
   logic                  flush_s;

   // Saturated K, next fetch index and abort qualification
   always_comb begin
      k_sat_s  = KW'(sat_limit(32'(k_len), 32'(MAX_K)));
      k_next_s = k_cnt_r + K_ONE;
      k_last_s = (k_cnt_r == (k_len_r - K_ONE));
      flush_s  = abort & busy_r;
   end

   // Pass sequencer: state, counters and registered control outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         k_len_r        <= '0;
         k_cnt_r        <= '0;
         drain_cnt_r    <= '0;
         rd_en_r        <= 1'b0;
         rd_addr_r      <= '0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         result_valid_r <= 1'b0;
         array_clear_r  <= 1'b0;
         pe_enable_r    <= 1'b0;
      end else if (flush_s) begin
         state_r        <= ST_IDLE;
         k_cnt_r        <= '0;
         drain_cnt_r    <= '0;
         rd_en_r        <= 1'b0;
         rd_addr_r      <= '0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         result_valid_r <= 1'b0;
         array_clear_r  <= 1'b0;
         pe_enable_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r        <= ST_CLEAR;
                  k_len_r        <= k_sat_s;
                  busy_r         <= 1'b1;
                  array_clear_r  <= 1'b1;
                  result_valid_r <= 1'b0;
               end
            end
            ST_CLEAR: begin
               array_clear_r <= 1'b0;
               if (k_len_r == '0) begin
                  state_r        <= ST_DONE;
                  busy_r         <= 1'b0;
                  done_r         <= 1'b1;
                  result_valid_r <= 1'b1;
               end else begin
                  state_r     <= ST_FEED;
                  pe_enable_r <= 1'b1;
                  rd_en_r     <= 1'b1;
                  rd_addr_r   <= '0;
                  k_cnt_r     <= '0;
               end
            end
            ST_FEED: begin
               if (k_last_s) begin
                  state_r     <= ST_DRAIN;
                  rd_en_r     <= 1'b0;
                  drain_cnt_r <= '0;
               end else begin
                  k_cnt_r   <= k_next_s;
                  rd_addr_r <= k_next_s[ADDR_WIDTH-1:0];
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == DRAIN_LAST) begin
                  state_r        <= ST_DONE;
                  pe_enable_r    <= 1'b0;
                  busy_r         <= 1'b0;
                  done_r         <= 1'b1;
                  result_valid_r <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               rd_en_r        <= 1'b0;
               busy_r         <= 1'b0;
               done_r         <= 1'b0;
               result_valid_r <= 1'b0;
               array_clear_r  <= 1'b0;
               pe_enable_r    <= 1'b0;
            end
         endcase
      end
   end

   // Buffer data returns one cycle after the strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_r <= 1'b0;
      end else if (flush_s) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_en_r;
      end
   end

   skew_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
      .clk      (clk),
      .rst_n    (reset),
      .shift_en (busy_r),
      .flush    (flush_s),
      .in_valid (rd_valid_r),
      .in_flat  (a_rd_data),
      .out_flat (array_in_a_flat)
   );

   skew_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
      .clk      (clk),
      .rst_n    (reset),
      .shift_en (busy_r),
      .flush    (flush_s),
      .in_valid (rd_valid_r),
      .in_flat  (b_rd_data),
      .out_flat (array_in_b_flat)
   );

   assign busy         = busy_r;
   assign done         = done_r;
   assign result_valid = result_valid_r;
   assign a_rd_en      = rd_en_r;
   assign b_rd_en      = rd_en_r;
   assign a_rd_addr    = rd_addr_r;
   assign b_rd_addr    = rd_addr_r;
   assign array_clear  = array_clear_r;
   assign pe_enable    = pe_enable_r;

endmodule

// File: tb/tb_systolic_controller.sv
// Bench: controller driving a behavioural array and operand buffers; C checked against a matrix product.
module tb_systolic_controller;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int MAX_K = 64;
   localparam int AW    = 6;

   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic [AW:0]       k_len;
   logic              busy, done, result_valid;
   logic              a_rd_en, b_rd_en;
   logic [AW-1:0]     a_rd_addr, b_rd_addr;
   logic [N*DW-1:0]   a_rd_data, b_rd_data;
   logic              array_clear, pe_enable;
   logic [N*DW-1:0]   array_in_a_flat, array_in_b_flat;

   int checks = 0;
   int errors = 0;

   logic signed [DW-1:0] a_mem [MAX_K][N];
   logic signed [DW-1:0] b_mem [MAX_K][N];
   longint               acc   [N][N];
   logic signed [DW-1:0] ar    [N][N];
   logic signed [DW-1:0] br    [N][N];

   systolic_controller #(.N(N), .DATA_WIDTH(DW), .MAX_K(MAX_K)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .k_len(k_len),
      .busy(busy), .done(done), .result_valid(result_valid),
      .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
      .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
      .array_clear(array_clear), .pe_enable(pe_enable),
      .array_in_a_flat(array_in_a_flat), .array_in_b_flat(array_in_b_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Operand buffers with one cycle read latency
   always @(posedge clk) begin
      if (a_rd_en) for (int i = 0; i < N; i++) a_rd_data[i*DW +: DW] <= a_mem[a_rd_addr][i];
      if (b_rd_en) for (int j = 0; j < N; j++) b_rd_data[j*DW +: DW] <= b_mem[b_rd_addr][j];
   end

   function automatic logic signed [DW-1:0] a_at(int i, int j);
      if (j == 0) return array_in_a_flat[i*DW +: DW];
      else return ar[i][j-1];
   endfunction

   function automatic logic signed [DW-1:0] b_at(int i, int j);
      if (i == 0) return array_in_b_flat[j*DW +: DW];
      else return br[i-1][j];
   endfunction

   // Output-stationary array: A moves right, B moves down, each PE accumulates
   always @(posedge clk) begin
      if (array_clear) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= 0; ar[i][j] <= '0; br[i][j] <= '0;
            end
      end else if (pe_enable) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ar[i][j]  <= a_at(i, j);
               br[i][j]  <= b_at(i, j);
               acc[i][j] <= acc[i][j] + longint'(a_at(i, j)) * longint'(b_at(i, j));
            end
      end
   end

   function automatic logic [10:0] out_bits();
      return {busy, done, result_valid, a_rd_en, b_rd_en, array_clear, pe_enable,
              |a_rd_addr, |b_rd_addr, |array_in_a_flat, |array_in_b_flat};
   endfunction

   // mode 0 random, 1 identity/sequential, 2 outer product, 3 extreme negatives
   task automatic fill(input int mode);
      for (int k = 0; k < MAX_K; k++)
         for (int i = 0; i < N; i++) begin
            case (mode)
               1: begin
                  a_mem[k][i] = (i == k) ? 16'sd1 : 16'sd0;
                  b_mem[k][i] = DW'(k * N + i + 1);
               end
               2: begin
                  a_mem[k][i] = DW'(i + 1);
                  b_mem[k][i] = DW'(i + 5);
               end
               3: begin
                  a_mem[k][i] = 16'sh8000;
                  b_mem[k][i] = ($urandom_range(0, 1) == 0) ? 16'sh8000 : DW'($urandom);
               end
               default: begin
                  a_mem[k][i] = DW'($urandom);
                  b_mem[k][i] = DW'($urandom);
               end
            endcase
         end
   endtask

   task automatic run_pass(input int k_req, input bit spam, input int abort_at);
      int     k_eff, lat, rd_idx, n_done;
      bit     aborted, rd_exp;
      longint sum;
      k_eff   = (k_req > MAX_K) ? MAX_K : k_req;
      lat     = (k_eff == 0) ? 2 : k_eff + 2 * N + 2;
      rd_idx  = 0;
      n_done  = 0;
      aborted = 1'b0;
      k_len   = 7'(k_req);
      start   = 1'b1;
      for (int c = 1; c <= lat + 4; c++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (abort_at != 0 && c == abort_at + 1) begin
            aborted = 1'b1;
            chk("abort_flush", |{array_in_a_flat, array_in_b_flat}, 1'b0);
         end
         if (aborted) begin
            chk("abort_idle", {busy, done, result_valid, pe_enable, a_rd_en}, 5'd0);
         end else begin
            rd_exp = (k_eff > 0) && (c >= 2) && (c <= k_eff + 1);
            chk("busy", busy, c < lat);
            chk("array_clear", array_clear, c == 1);
            chk("pe_enable", pe_enable, (k_eff > 0) && (c >= 2) && (c <= k_eff + 2 * N + 1));
            chk("rd_en", {a_rd_en, b_rd_en}, {2{rd_exp}});
            chk("done", done, c == lat);
            chk("result_valid", result_valid, c >= lat);
            if (a_rd_en) begin
               chk("a_rd_addr", a_rd_addr, rd_idx);
               chk("b_rd_addr", b_rd_addr, rd_idx);
               rd_idx++;
            end
         end
         start = spam && (c < lat);
         if (spam) k_len = 7'($urandom_range(1, 100));
         abort = (c == abort_at);
      end
      abort = 1'b0;
      start = 1'b0;
      if (aborted) begin
         chk("abort_no_done", n_done, 0);
      end else begin
         chk("done_count", n_done, 1);
         chk("rd_count", rd_idx, k_eff);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               sum = 0;
               for (int k = 0; k < k_eff; k++) sum += longint'(a_mem[k][i]) * longint'(b_mem[k][j]);
               chk($sformatf("c[%0d][%0d]", i, j), acc[i][j], sum);
            end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0;
      a_rd_data = '0; b_rd_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", out_bits(), 11'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_outs", out_bits(), 11'd0);

      fill(1); run_pass(4, 1'b0, 0);
      fill(2); run_pass(1, 1'b0, 0);
      fill(0); run_pass(0, 1'b0, 0);
      fill(0); run_pass(6, 1'b1, 0);
      fill(0); run_pass(8, 1'b0, 4);
      fill(0); run_pass(8, 1'b0, 0);

      // reset asserted in the middle of DRAIN
      fill(0);
      k_len = 7'd8;
      start = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("pre_reset_busy", busy, 1'b1);
      #2 reset = 1'b0;
      #1 chk("async_reset", out_bits(), 11'd0);
      @(posedge clk); #1;
      chk("reset_hold", out_bits(), 11'd0);
      @(negedge clk) reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("no_restart", {busy, done, a_rd_en, pe_enable}, 4'd0);
      end
      fill(3); run_pass(12, 1'b0, 0);

      for (int t = 0; t < 4; t++) begin
         fill(0);
         run_pass($urandom_range(1, 20), 1'b0, 0);
      end
      fill(0); run_pass(100, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
